// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host interface.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    function automatic int unsigned us_to_cycles(
        input int unsigned freq,
        input int unsigned us
    );
        return (freq / 32'd1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample debounce.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples that disagree with the current level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain
// clock/data lines through low-enables.
`timescale 1ns/1ps
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 25000000,
    parameter int unsigned INHIBIT_US     = 100,
    parameter int unsigned REQ_TIMEOUT_US = 15000,
    parameter int unsigned BIT_TIMEOUT_US = 2000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned REQ_CYCLES     = us_to_cycles(CLK_FREQ_HZ, REQ_TIMEOUT_US);
    localparam int unsigned BIT_CYCLES     = us_to_cycles(CLK_FREQ_HZ, BIT_TIMEOUT_US);
    localparam int unsigned MAX_A          = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned MAX_CYCLES     = (MAX_A > BIT_CYCLES) ? MAX_A : BIT_CYCLES;
    localparam int unsigned TW             = $clog2(MAX_CYCLES);

    // Loaded with N-1 so that zero is reached exactly N cycles after the load
    localparam logic [TW-1:0] T_INH = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] T_REQ = TW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] T_BIT = TW'(BIT_CYCLES - 1);

    state_t        state;
    logic [9:0]    frame;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic          clk_f;
    logic          data_f;
    logic          clk_prev;
    logic          fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data_in),
        .level (data_f)
    );

    assign fall     = clk_prev & ~clk_f;
    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            clk_prev    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            done     <= 1'b0;
            error    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        err_code   <= ERR_NONE;
                        timer      <= T_INH;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (timer == '0) begin
                        ps2_data_oe <= 1'b1;
                        state       <= S_START;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_START: begin
                    ps2_clk_oe <= 1'b0;
                    timer      <= T_REQ;
                    bit_cnt    <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (fall) begin
                        ps2_data_oe <= ~frame[bit_cnt];
                        bit_cnt     <= bit_cnt + 4'd1;
                        timer       <= T_BIT;
                        if (bit_cnt == 4'd9) state <= S_ACK;
                    end else if (timer == '0) begin
                        ps2_data_oe <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        if (!data_f) begin
                            timer <= T_BIT;
                            state <= S_WAIT_IDLE;
                        end else begin
                            ps2_data_oe <= 1'b0;
                            error       <= 1'b1;
                            err_code    <= ERR_NOACK;
                            state       <= S_IDLE;
                        end
                    end else if (timer == '0) begin
                        ps2_data_oe <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_f && data_f) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (timer == '0) begin
                        ps2_data_oe <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural keyboard on the open-drain lines.
// DUT runs at 1 MHz so timeouts are 100/15000/2000 cycles; device clock is 12.5 kHz.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int CLK_HZ  = 1000000;
    localparam int INH_CYC = 100;
    localparam int REQ_CYC = 15000;
    localparam int BIT_CYC = 2000;
    localparam int FLEN    = 8;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk_low;
    logic       dev_data_low;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    logic [10:0] sb[$];

    always #5 clk = ~clk;

    // Wired-AND open-drain lines with pull-ups
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ_HZ    (CLK_HZ),
        .INHIBIT_US     (100),
        .REQ_TIMEOUT_US (15000),
        .BIT_TIMEOUT_US (2000),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (done && error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        p = (ones % 2 == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_release(output int inh, output bit ok);
        inh = 0;
        ok  = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ps2_clk_oe) inh++;
            else if (ps2_data_oe) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic dev_clock(input bit glitch, output logic b);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        b = ps2_data_in;
        if (glitch) begin
            repeat (3) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2 - 8) @(negedge clk);
        end else begin
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic full_transfer(input logic [7:0] b, input bit glitch,
                                 input bit chk_inh, input bit poke);
        int inh;
        bit ok;
        int d0;
        int e0;
        logic [10:0] cap;
        logic [10:0] exp;
        sb.push_back(frame_of(b));
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        if (poke) begin
            repeat (10) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("busy_during_poke", busy, 1);
        end
        wait_release(inh, ok);
        check("release_seen", ok, 1);
        if (chk_inh) check($sformatf("inhibit_len_%0d", inh), inh >= INH_CYC, 1);
        repeat (20) @(negedge clk);
        cap[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) dev_clock(glitch && i == 5, cap[i]);
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1;
                break;
            end
        end
        check("outcome_seen", ok, 1);
        repeat (5) @(negedge clk);
        exp = sb.pop_front();
        check($sformatf("frame_%02h", b), cap, exp);
        check("done_pulses", done_cnt - d0, 1);
        check("no_error", err_cnt - e0, 0);
        check("err_code_ok", err_code, 2'b00);
        check("ready_after", tx_ready, 1);
    endtask

    initial begin
        int inh;
        bit ok;
        int n;
        int d0;
        int e0;
        logic b;
        reset        = 1'b1;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        full_transfer(8'hED, 0, 1, 0);
        full_transfer(8'h00, 0, 0, 0);
        full_transfer(8'hFF, 0, 0, 0);
        full_transfer(8'h01, 1, 0, 0);

        // No ACK at the 11th fall
        d0 = done_cnt;
        send(8'h3C);
        wait_release(inh, ok);
        check("noack_release", ok, 1);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 10; i++) dev_clock(0, b);
        dev_clk_low = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (error) begin
                ok = 1;
                break;
            end
        end
        check("noack_error", ok, 1);
        check("noack_code", err_code, 2'b10);
        check("noack_clk_oe", ps2_clk_oe, 0);
        check("noack_data_oe", ps2_data_oe, 0);
        check("noack_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        check("noack_code_held", err_code, 2'b10);
        check("noack_no_done", done_cnt - d0, 0);

        // Device never clocks
        send(8'h12);
        check("accept_clears_code", err_code, 2'b00);
        wait_release(inh, ok);
        check("req_release", ok, 1);
        n = 0;
        for (int i = 0; i < REQ_CYC + 100; i++) begin
            @(negedge clk);
            n++;
            if (error) break;
        end
        check("req_timeout_cycles", n, REQ_CYC);
        check("req_timeout_code", err_code, 2'b01);

        // Device stops after four falls; window covers sync + filter delay
        send(8'h5A);
        wait_release(inh, ok);
        check("stall_release", ok, 1);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 3; i++) dev_clock(0, b);
        dev_clk_low = 1'b1;
        n = 0;
        for (int i = 0; i < BIT_CYC + 200; i++) begin
            @(negedge clk);
            n++;
            if (n == HALF) dev_clk_low = 1'b0;
            if (error) break;
        end
        dev_clk_low = 1'b0;
        check($sformatf("bit_timeout_window_%0d", n),
              (n >= BIT_CYC) && (n <= BIT_CYC + FLEN + 6), 1);
        check("bit_timeout_code", err_code, 2'b01);
        repeat (20) @(negedge clk);

        // Reset while data bit 4 (a zero) is on the line
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hC3);
        wait_release(inh, ok);
        check("rstmid_release", ok, 1);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 4; i++) dev_clock(0, b);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_bit4_driven", ps2_data_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_clk_oe", ps2_clk_oe, 0);
        check("rstmid_data_oe", ps2_data_oe, 0);
        check("rstmid_ready", tx_ready, 1);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
        check("rstmid_no_error", err_cnt - e0, 0);
        full_transfer(8'hF4, 0, 0, 0);

        // tx_valid while busy is dropped
        full_transfer(8'hA5, 0, 0, 1);

        check("done_error_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF3 typematic.
- Complements the existing PS/2 receive path and runs on the same 25 MHz `clk` domain.
- Drives the open-drain ps2Clk/ps2Data lines through low-enables. The top level maps each line as enable=1 → drive 0, enable=0 → high-Z.
- `busy` tells the receiver and keyboard matrix to ignore line activity while a command is in flight.

Parameters:
- CLK_FREQ_HZ, 25000000, system clock frequency.
- INHIBIT_US, 100, minimum time the host holds clock low before the start bit.
- REQ_TIMEOUT_US, 15000, maximum time from clock release to the device's first falling edge.
- BIT_TIMEOUT_US, 2000, maximum time between consecutive device falling edges.
- FILTER_LEN, 8, consecutive equal samples required before a filtered line changes level.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte sent and acknowledged.
- error  out  1  one-cycle pulse: transfer aborted.
- err_code  out  2  01 = timeout, 10 = no ACK; held until the next accept.
- ps2_clk_in  in  1  raw ps2Clk pin level.
- ps2_data_in  in  1  raw ps2Data pin level.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.

Behaviour:
- Reset values: tx_ready=1, busy=0, done=0, error=0, err_code=00, both oe=0, state IDLE. Reset mid-transfer releases both lines on the next edge; no pulse is emitted.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then a glitch filter. The filtered level changes only after FILTER_LEN identical samples. Filtered reset level is 1.
  - fall = filtered clock 1→0, a single-cycle strobe.
- Handshake: transfer is accepted when tx_valid && tx_ready.
  - tx_data is latched.
  - Parity is computed as odd parity: ~^tx_data.
  - err_code is cleared on accept.
  - tx_valid while busy is ignored, with no queueing.
- States:
  - IDLE: both oe=0. Accept → INHIBIT.
  - INHIBIT: clk_oe=1. Counter runs for INHIBIT_CYCLES = CLK_FREQ_HZ/1e6*INHIBIT_US cycles (2500 at default), then data_oe=1 → START.
  - START: clk_oe=1 and data_oe=1 for exactly one cycle. Then clk_oe=0 (clock released, start bit 0 presented), timer loaded with REQ_TIMEOUT → SHIFT with bit_cnt=0.
  - SHIFT: on each fall, data_oe = ~frame[bit_cnt], frame = {1 stop, parity, d7..d0}, sent LSB first, and bit_cnt increments.
    - bit_cnt 0..7: data bits.
    - bit_cnt 8: parity.
    - bit_cnt 9: stop bit (data_oe=0).
    - Timer reloads with BIT_TIMEOUT on every fall. After the stop fall → ACK.
  - ACK: on the next fall, sample filtered data. 0 → WAIT_IDLE. 1 → abort, err_code=10.
  - WAIT_IDLE: wait until filtered clock=1 and data=1. Then done=1 for one cycle → IDLE.
- Timeout:
  - The timer runs in SHIFT, ACK and WAIT_IDLE (WAIT_IDLE uses BIT_TIMEOUT).
  - Expiry → abort, err_code=01.
  - Abort: both oe=0, error=1 for one cycle, then IDLE.
  - Timer resolution is one clk. Expiry occurs exactly timeout_cycles after the load.
- Counter widths: $clog2 of the largest cycle count, which is 375000 → 19 bits at default.
- Device clock edges outside SHIFT/ACK are ignored.
- done and error are never high in the same cycle.

Decomposition:
- Shared package ps2_pkg:
  - err_code localparams ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_NOACK=2'b10.
  - State enum.
  - Function us_to_cycles(freq, us).
- Sub-module ps2_line_filter: synchroniser plus FILTER_LEN debounce, instantiated twice (clock and data). The existing receiver can reuse it later.

Test Plan:
- Device model clocks at 12.5 kHz and ACKs. Send 0xED → clk_oe high for ≥2500 cycles. Data line after start bit 0 reads 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once, err_code=00.
- Payload parity sweep:
  - 0x00 → parity 1.
  - 0xFF → parity 1.
  - 0x01 → parity 0.
  - Each transfer completes with done and no error.
- Device leaves data high at the 11th fall → error pulse, err_code=10, both oe=0 next cycle, tx_ready=1.
- Device never clocks → error exactly 375000 cycles after clock release, err_code=01. Separately, device stops after 4 edges → error 50000 cycles after the last fall.
- Assert reset during data bit 4 → both oe=0 and tx_ready=1 on the next cycle, no done/error. A following 0xF4 transfer succeeds.
- tx_valid pulsed with 0x55 while busy → ignored, the original byte completes. A 5-cycle low glitch on ps2_clk_in in SHIFT → no bit advance.
